// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver that deglitches key_clk, deframes 11-bit frames and folds E0/F0 prefixes into flags.
// Ports: clk, resetn (async active-low); key_clk, key_data (raw PS/2 lines);
//   scan_code/scan_valid/scan_break/scan_ext (decoded byte + strobe + prefix flags);
//   frame_err (stop/parity/timeout strobe); busy (FSM not idle).
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_key_rx #(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_clk,
  input  logic       key_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       scan_break,
  output logic       scan_ext,
  output logic       frame_err,
  output logic       busy
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic [1:0]    kc_s_q, kc_s_d, kd_s_q, kd_s_d;
  logic          kc_f_q, kc_f_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [TW-1:0] to_q, to_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d, ext_q, ext_d, brk_q, brk_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d, sbrk_q, sbrk_d, sext_q, sext_d, err_q, err_d;
  logic          kc, kd, differ, flip, timeout, fall, bad;
  always_comb begin
    kc_s_d  = {kc_s_q[0], key_clk};
    kd_s_d  = {kd_s_q[0], key_data};
    kc      = kc_s_q[1];
    kd      = kd_s_q[1];
    differ  = kc != kc_f_q;
    flip    = differ && (filt_q == FW'(FILTER_CYCLES - 1));
    filt_d  = (differ && !flip) ? filt_q + FW'(1) : '0;
    kc_f_d  = flip ? kc : kc_f_q;
    timeout = (state_q != IDLE) && (to_q == TW'(TIMEOUT_CYCLES - 1));
    // a timeout wins over a falling edge landing in the same cycle
    fall    = flip && !kc && !timeout;
    to_d    = (state_q == IDLE || fall || timeout) ? '0 : to_q + TW'(1);
    bad     = !kd || (PAR_EN && !(^{shift_q, par_q}));
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    code_d  = code_q;
    sbrk_d  = sbrk_q;
    sext_d  = sext_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = kd ? IDLE : DATA;
          bit_d   = '0;
        end
        DATA: begin
          shift_d = {kd, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = kd;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (bad) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            code_d  = shift_q;
            sbrk_d  = brk_q;
            sext_d  = ext_q;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kc_s_q  <= 2'b11;
      kd_s_q  <= 2'b11;
      kc_f_q  <= 1'b1;
      filt_q  <= '0;
      to_q    <= '0;
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      code_q  <= '0;
      valid_q <= 1'b0;
      sbrk_q  <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      kc_s_q  <= kc_s_d;
      kd_s_q  <= kd_s_d;
      kc_f_q  <= kc_f_d;
      filt_q  <= filt_d;
      to_q    <= to_d;
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      sbrk_q  <= sbrk_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
    end
  end
  assign scan_code  = code_q;
  assign scan_valid = valid_q;
  assign scan_break = sbrk_q;
  assign scan_ext   = sext_q;
  assign frame_err  = err_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx: directed plus random PS/2 frames checked against a frame-level prefix model.
module tb_ps2_key_rx;
  logic clk = 1'b0, resetn = 1'b0, key_clk = 1'b1, key_data = 1'b1;
  logic [7:0] scan_code;
  logic scan_valid, scan_break, scan_ext, frame_err, busy;
  int n_assert = 0, n_fail = 0;
  int nv = 0, ne = 0;
  logic [7:0] cap_code;
  logic cap_brk, cap_ext;
  logic m_ext = 1'b0, m_brk = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  ps2_key_rx dut (
    .clk(clk), .resetn(resetn), .key_clk(key_clk), .key_data(key_data),
    .scan_code(scan_code), .scan_valid(scan_valid), .scan_break(scan_break),
    .scan_ext(scan_ext), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (scan_valid || frame_err) begin
      n_assert++;
      assert (!(scan_valid && frame_err)) else begin
        n_fail++;
        $error("FAIL strobe_overlap observed=1 expected=0");
      end
    end
    if (scan_valid) begin
      nv++;
      cap_code = scan_code;
      cap_brk  = scan_break;
      cap_ext  = scan_ext;
    end
    if (frame_err) ne++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic v);
    key_data = v;
    repeat (20) @(posedge clk);
    key_clk = 1'b0;
    repeat (20) @(posedge clk);
    key_clk = 1'b1;
  endtask
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
    key_data = 1'b1;
  endtask
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    return {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
  endfunction
  task automatic run_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    int v0, e0;
    bit ev, ee;
    logic [7:0] ec;
    logic eb, ex;
    v0 = nv;
    e0 = ne;
    ev = 0; ee = 0; ec = b; eb = m_brk; ex = m_ext;
    if (stop_bad || (PAR_EN && par_bad)) begin
      ee = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      ev = 1; m_ext = 0; m_brk = 0;
    end
    send_bits(frame_bits(b, par_bad, stop_bad), 11);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk($sformatf("valid_cnt_%02h", b), nv - v0, ev);
    chk($sformatf("err_cnt_%02h", b), ne - e0, ee);
    chk("busy_after_frame", busy, 0);
    if (ev) begin
      chk("scan_code", cap_code, ec);
      chk("scan_break", cap_brk, eb);
      chk("scan_ext", cap_ext, ex);
    end
  endtask
  initial begin
    int v0, e0, k;
    logic [7:0] rb;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_code", scan_code, 0);
    chk("rst_strobes", {scan_valid, scan_break, scan_ext, frame_err}, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    run_frame(8'h1D, 0, 0);
    run_frame(8'hF0, 0, 0);
    run_frame(8'h1D, 0, 0);
    run_frame(8'hE0, 0, 0);
    run_frame(8'hF0, 0, 0);
    run_frame(8'h75, 0, 0);
    run_frame(8'h75, 0, 0);
    run_frame(8'h1C, 1, 0);
    run_frame(8'h12, 0, 1);
    // short low glitch on key_clk with data low must not start a frame
    v0 = nv; e0 = ne;
    key_data = 1'b0;
    key_clk = 1'b0;
    repeat (3) @(posedge clk);
    key_clk = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_strobes", (nv - v0) + (ne - e0), 0);
    key_data = 1'b1;
    // prefix then a frame stalled after 4 data bits
    run_frame(8'hE0, 0, 0);
    v0 = nv; e0 = ne;
    send_bits(frame_bits(8'h23, 0, 0), 5);
    repeat (4000) @(posedge clk);
    @(negedge clk);
    chk("stall_busy_early", busy, 1);
    chk("stall_no_err_early", ne - e0, 0);
    k = 0;
    while (ne == e0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_err", ne - e0, 1);
    chk("timeout_no_valid", nv - v0, 0);
    @(negedge clk);
    chk("timeout_busy", busy, 0);
    m_ext = 0; m_brk = 0;
    run_frame(8'h23, 0, 0);
    // reset mid-frame after 5 data bits
    send_bits(frame_bits(8'h44, 0, 0), 6);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_code", scan_code, 0);
    chk("midrst_outs", {scan_valid, scan_break, scan_ext, frame_err, busy}, 0);
    repeat (5) @(posedge clk);
    resetn = 1'b1;
    m_ext = 0; m_brk = 0;
    v0 = nv; e0 = ne;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("postrst_strobes", (nv - v0) + (ne - e0), 0);
    run_frame(8'h1B, 0, 0);
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 5);
      rb = (k == 0) ? 8'hE0 : (k == 1) ? 8'hF0 : 8'($urandom);
      run_frame(rb, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  initial begin
    #50ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
